// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter
// Round-robin front end that shares one FP16 adder controller among N_REQ
// requesters. One transaction is in flight at a time: a request is issued as a
// single-cycle Add_data_valid pulse, and the controller's single-cycle
// Add_dataout_valid result is parked on Rsp_* until the owner acknowledges it.
// A watchdog synthesises a quiet-NaN response if the controller never answers.
module fpu_add_arbiter #(
  parameter int  N_REQ   = 4,
  parameter int  TIMEOUT = 64,
  localparam int ID_W    = $clog2(N_REQ),
  localparam int DATA_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        Req_valid,
  input  logic [DATA_W*N_REQ-1:0] Req_datain1,
  input  logic [DATA_W*N_REQ-1:0] Req_datain2,
  input  logic [3*N_REQ-1:0]      Req_mode,
  output logic [N_REQ-1:0]        Req_ack,
  output logic [N_REQ-1:0]        Rsp_valid,
  output logic [DATA_W-1:0]       Rsp_dataout,
  output logic [2:0]              Rsp_exc,
  input  logic [N_REQ-1:0]        Rsp_ack,
  output logic [DATA_W-1:0]       Add_datain1,
  output logic [DATA_W-1:0]       Add_datain2,
  output logic [2:0]              Add_mode,
  output logic                    Add_data_valid,
  input  logic [DATA_W-1:0]       Add_dataout,
  input  logic [2:0]              Add_exc,
  input  logic                    Add_dataout_valid,
  output logic                    Busy,
  output logic [ID_W-1:0]         Grant_id,
  output logic [7:0]              Drop_cnt
);

  // Watchdog must be able to hold TIMEOUT-1.
  localparam int WD_W = $clog2(TIMEOUT + 1);

  // Quiet NaN returned when the controller stays silent.
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'h7FC0;
  localparam logic [2:0]        TIMEOUT_EXC  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     grant_q;
  logic [WD_W-1:0]     wd_q;

  logic [N_REQ-1:0]    req_ack_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [2:0]          rsp_exc_q;
  logic [DATA_W-1:0]   add_d1_q;
  logic [DATA_W-1:0]   add_d2_q;
  logic [2:0]          add_mode_q;
  logic                add_vld_q;
  logic                busy_q;
  logic [7:0]          drop_q;

  logic [ID_W-1:0]     grant_d;
  logic                wd_expired_d;
  logic                stray_d;

  // Saturating increment for the dropped-response counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Pointer advance with wrap at N_REQ (N_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] g);
    return (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  // Index to one-hot requester vector.
  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] g);
    logic [N_REQ-1:0] r;
    r    = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  // First requesting index at or after ptr, searching upward with wrap.
  // Walking k downward lets the smallest distance from ptr win.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  assign grant_d      = rr_pick(Req_valid, ptr_q);
  assign wd_expired_d = (wd_q == WD_W'(TIMEOUT - 1));
  assign stray_d      = Add_dataout_valid && (state_q != WAIT);

  // Arbitration FSM: issue, wait for result or watchdog, hold until acknowledged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      wd_q        <= '0;
      req_ack_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_exc_q   <= '0;
      add_d1_q    <= '0;
      add_d2_q    <= '0;
      add_mode_q  <= '0;
      add_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      // Handshake pulses last exactly one cycle.
      req_ack_q <= '0;
      add_vld_q <= 1'b0;

      // A result with no transaction waiting for it is counted and discarded.
      if (stray_d) drop_q <= sat_inc8(drop_q);

      unique case (state_q)
        IDLE: begin
          if (|Req_valid) begin
            add_d1_q   <= Req_datain1[DATA_W*int'(grant_d) +: DATA_W];
            add_d2_q   <= Req_datain2[DATA_W*int'(grant_d) +: DATA_W];
            add_mode_q <= Req_mode[3*int'(grant_d) +: 3];
            grant_q    <= grant_d;
            req_ack_q  <= onehot(grant_d);
            add_vld_q  <= 1'b1;
            wd_q       <= '0;
            busy_q     <= 1'b1;
            state_q    <= WAIT;
          end
        end

        WAIT: begin
          wd_q <= wd_q + 1'b1;
          // A real result on the watchdog's terminal cycle takes priority.
          if (Add_dataout_valid) begin
            rsp_data_q  <= Add_dataout;
            rsp_exc_q   <= Add_exc;
            rsp_valid_q <= onehot(grant_q);
            state_q     <= RESP;
          end else if (wd_expired_d) begin
            rsp_data_q  <= TIMEOUT_DATA;
            rsp_exc_q   <= TIMEOUT_EXC;
            rsp_valid_q <= onehot(grant_q);
            state_q     <= RESP;
          end
        end

        RESP: begin
          // Only the owner's acknowledge releases the response.
          if (Rsp_ack[grant_q]) begin
            rsp_valid_q <= '0;
            ptr_q       <= wrap_inc(grant_q);
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Req_ack        = req_ack_q;
  assign Rsp_valid      = rsp_valid_q;
  assign Rsp_dataout    = rsp_data_q;
  assign Rsp_exc        = rsp_exc_q;
  assign Add_datain1    = add_d1_q;
  assign Add_datain2    = add_d2_q;
  assign Add_mode       = add_mode_q;
  assign Add_data_valid = add_vld_q;
  assign Busy           = busy_q;
  assign Grant_id       = grant_q;
  assign Drop_cnt       = drop_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb_fpu_add_arbiter
// Scenario-driven bench for fpu_add_arbiter with an adder-controller stub and
// a round-robin reference model (pointer + first-requester-from-pointer rule).
module tb_fpu_add_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic [N-1:0]      Req_valid;
  logic [16*N-1:0]   Req_datain1;
  logic [16*N-1:0]   Req_datain2;
  logic [3*N-1:0]    Req_mode;
  logic [N-1:0]      Req_ack;
  logic [N-1:0]      Rsp_valid;
  logic [15:0]       Rsp_dataout;
  logic [2:0]        Rsp_exc;
  logic [N-1:0]      Rsp_ack;
  logic [15:0]       Add_datain1;
  logic [15:0]       Add_datain2;
  logic [2:0]        Add_mode;
  logic              Add_data_valid;
  logic [15:0]       Add_dataout;
  logic [2:0]        Add_exc;
  logic              Add_dataout_valid;
  logic              Busy;
  logic [1:0]        Grant_id;
  logic [7:0]        Drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;
  int drop_m  = 0;

  typedef struct {
    bit          issued;
    int          issue_ticks;
    logic [N-1:0] ack;
    logic [1:0]  gid;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [2:0]  mode;
    logic [N-1:0] ack_after;
    int          resp_cycle;
    logic [N-1:0] rsp_valid;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_exc;
    bit          stable;
    logic [N-1:0] rsp_after;
    logic        busy_after;
  } obs_t;

  fpu_add_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .Req_valid(Req_valid), .Req_datain1(Req_datain1), .Req_datain2(Req_datain2),
    .Req_mode(Req_mode), .Req_ack(Req_ack),
    .Rsp_valid(Rsp_valid), .Rsp_dataout(Rsp_dataout), .Rsp_exc(Rsp_exc), .Rsp_ack(Rsp_ack),
    .Add_datain1(Add_datain1), .Add_datain2(Add_datain2), .Add_mode(Add_mode),
    .Add_data_valid(Add_data_valid), .Add_dataout(Add_dataout), .Add_exc(Add_exc),
    .Add_dataout_valid(Add_dataout_valid),
    .Busy(Busy), .Grant_id(Grant_id), .Drop_cnt(Drop_cnt)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference rule: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_ops(input int i);
    Req_datain1[16*i +: 16] = 16'($urandom);
    Req_datain2[16*i +: 16] = 16'($urandom);
    Req_mode[3*i +: 3]      = 3'($urandom);
  endtask

  // Stimulus driver (no checking): waits for issue, plays the adder stub with
  // response latency lat (-1 = never), holds the response ack_delay cycles
  // (acking only foreign bits), then acks and records what it observed.
  task automatic run_txn(input int lat, input logic [15:0] res, input logic [2:0] exc,
                         input int ack_delay, input bit keep, input logic [N-1:0] add_mask,
                         input logic [N-1:0] ack_keep_mask, input bit stray, output obs_t o);
    int cyc;
    bit found;
    o = '{default: '0};
    o.resp_cycle = -1;
    for (int i = 1; i <= 4 && !o.issued; i++) begin
      tick();
      if (Add_data_valid === 1'b1) begin
        o.issued = 1'b1;
        o.issue_ticks = i;
      end
    end
    if (!o.issued) return;
    o.ack = Req_ack; o.gid = Grant_id;
    o.d1 = Add_datain1; o.d2 = Add_datain2; o.mode = Add_mode;
    Req_valid = (keep ? Req_valid : (Req_valid & ~Req_ack)) | add_mask;
    cyc = 0;
    found = 1'b0;
    for (int k = 0; k < TO + 8 && !found; k++) begin
      if (cyc == lat) begin
        Add_dataout_valid = 1'b1; Add_dataout = res; Add_exc = exc;
      end else begin
        Add_dataout_valid = 1'b0;
      end
      tick();
      cyc++;
      if (cyc == 1) o.ack_after = Req_ack;
      if (Rsp_valid !== '0) found = 1'b1;
    end
    Add_dataout_valid = 1'b0;
    if (!found) return;
    o.resp_cycle = cyc;
    o.rsp_valid = Rsp_valid; o.rsp_data = Rsp_dataout; o.rsp_exc = Rsp_exc;
    o.stable = 1'b1;
    for (int k = 0; k < ack_delay; k++) begin
      Rsp_ack = ~o.rsp_valid;
      if (k == 0 && stray) begin
        Add_dataout_valid = 1'b1; Add_dataout = ~res; Add_exc = ~exc;
      end
      tick();
      Add_dataout_valid = 1'b0;
      if (Rsp_valid !== o.rsp_valid || Rsp_dataout !== o.rsp_data ||
          Rsp_exc !== o.rsp_exc || Add_data_valid !== 1'b0) o.stable = 1'b0;
    end
    Rsp_ack = o.rsp_valid;
    Req_valid = Req_valid & ack_keep_mask;
    tick();
    Rsp_ack = '0;
    o.rsp_after = Rsp_valid;
    o.busy_after = Busy;
  endtask

  task automatic test_reset();
    Req_valid = '0; Req_datain1 = '0; Req_datain2 = '0; Req_mode = '0; Rsp_ack = '0;
    Add_dataout = '0; Add_exc = '0; Add_dataout_valid = 1'b0;
    RST = 1'b1;
    tick(); tick();
    n_tests++;
    if ({Req_ack, Rsp_valid, Rsp_dataout, Rsp_exc, Add_datain1, Add_datain2, Add_mode,
         Add_data_valid, Busy, Grant_id, Drop_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all zero");
    end
    RST = 1'b0;
    tick(); tick();
    n_tests++;
    if ({Req_ack, Rsp_valid, Add_data_valid, Busy, Drop_cnt} !== '0) begin
      n_fail++; $display("FAIL idle_hold: got activity with no requests, required none");
    end
    ptr_m = 0; drop_m = 0;
  endtask

  task automatic test_single();
    obs_t o;
    int g;
    Req_datain1[15:0] = 16'h3F80; Req_datain2[15:0] = 16'h3F80; Req_mode[2:0] = 3'd0;
    Req_valid = 4'b0001;
    g = rr_pick(Req_valid, ptr_m);
    run_txn(5, 16'h4000, 3'b000, 3, 1'b0, '0, '1, 1'b0, o);
    n_tests++; if (!o.issued || o.issue_ticks != 1) begin n_fail++; $display("FAIL single_latency: got %0d ticks, required 1", o.issue_ticks); end
    n_tests++; if (o.ack !== oh(g)) begin n_fail++; $display("FAIL single_ack: got %b required %b", o.ack, oh(g)); end
    n_tests++; if (o.ack_after !== '0) begin n_fail++; $display("FAIL single_ack_pulse: got %b required 0000", o.ack_after); end
    n_tests++; if ({o.d1, o.d2, o.mode} !== {16'h3F80, 16'h3F80, 3'd0}) begin n_fail++; $display("FAIL single_operands: got %h %h %h required 3f80 3f80 0", o.d1, o.d2, o.mode); end
    n_tests++; if (o.resp_cycle != 6) begin n_fail++; $display("FAIL single_resp_cycle: got %0d required 6", o.resp_cycle); end
    n_tests++; if ({o.rsp_valid, o.rsp_data, o.rsp_exc} !== {4'b0001, 16'h4000, 3'b000}) begin n_fail++; $display("FAIL single_rsp: got %b %h %b required 0001 4000 000", o.rsp_valid, o.rsp_data, o.rsp_exc); end
    n_tests++; if (!o.stable) begin n_fail++; $display("FAIL single_hold: got unstable response, required stable"); end
    n_tests++; if (o.rsp_after !== '0 || o.busy_after !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b busy %b required 0000 busy 0", o.rsp_after, o.busy_after); end
    ptr_m = (g + 1) % N;
  endtask

  task automatic test_round_robin();
    obs_t o;
    int g;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    logic [15:0] res;
    logic [2:0] exc;
    RST = 1'b1; tick(); RST = 1'b0;
    ptr_m = 0; drop_m = 0;
    for (int i = 0; i < N; i++) set_ops(i);
    Req_valid = '1;
    for (int t = 0; t < 6; t++) begin
      g = rr_pick(Req_valid, ptr_m);
      res = 16'($urandom); exc = 3'($urandom);
      run_txn(3, res, exc, 0, 1'b1, '0, (t == 5) ? '0 : '1, 1'b0, o);
      n_tests++; if (o.ack !== oh(g) || o.gid !== 2'(order[t])) begin n_fail++; $display("FAIL rr_grant%0d: got ack %b id %0d required id %0d", t, o.ack, o.gid, order[t]); end
      n_tests++; if (o.ack_after !== '0) begin n_fail++; $display("FAIL rr_ack_pulse%0d: got %b required 0000", t, o.ack_after); end
      n_tests++; if (o.d1 !== Req_datain1[16*g +: 16] || o.mode !== Req_mode[3*g +: 3]) begin n_fail++; $display("FAIL rr_operands%0d: got %h required %h", t, o.d1, Req_datain1[16*g +: 16]); end
      n_tests++; if (o.resp_cycle != 4 || o.rsp_valid !== oh(g) || o.rsp_data !== res || o.rsp_exc !== exc) begin n_fail++; $display("FAIL rr_rsp%0d: got cyc %0d %b %h %b required cyc 4 %b %h %b", t, o.resp_cycle, o.rsp_valid, o.rsp_data, o.rsp_exc, oh(g), res, exc); end
      ptr_m = (g + 1) % N;
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    int g;
    set_ops(3);
    Req_valid = 4'b1000;
    g = rr_pick(Req_valid, ptr_m);
    run_txn(-1, 16'h0, 3'b0, 2, 1'b0, '0, '1, 1'b0, o);
    n_tests++; if (o.gid !== 2'(g)) begin n_fail++; $display("FAIL to_grant: got %0d required %0d", o.gid, g); end
    n_tests++; if (o.resp_cycle != TO) begin n_fail++; $display("FAIL to_wait_cycles: got %0d required %0d", o.resp_cycle, TO); end
    n_tests++; if ({o.rsp_valid, o.rsp_data, o.rsp_exc} !== {oh(g), 16'h7FC0, 3'b100}) begin n_fail++; $display("FAIL to_rsp: got %b %h %b required %b 7fc0 100", o.rsp_valid, o.rsp_data, o.rsp_exc, oh(g)); end
    n_tests++; if (o.rsp_after !== '0) begin n_fail++; $display("FAIL to_release: got %b required 0000", o.rsp_after); end
    ptr_m = (g + 1) % N;
    Add_dataout_valid = 1'b1; Add_dataout = 16'hBEEF; Add_exc = 3'b001;
    tick();
    Add_dataout_valid = 1'b0;
    drop_m++;
    n_tests++; if (Drop_cnt !== 8'(drop_m)) begin n_fail++; $display("FAIL to_stray_drop: got %0d required %0d", Drop_cnt, drop_m); end
    n_tests++; if (Rsp_valid !== '0 || Rsp_dataout !== 16'h7FC0 || Busy !== 1'b0) begin n_fail++; $display("FAIL to_stray_ignored: got %b %h busy %b required 0000 7fc0 busy 0", Rsp_valid, Rsp_dataout, Busy); end
  endtask

  task automatic test_terminal();
    obs_t o;
    int g;
    set_ops(1);
    Req_valid = 4'b0010;
    g = rr_pick(Req_valid, ptr_m);
    run_txn(TO - 1, 16'h1234, 3'b010, 1, 1'b0, '0, '1, 1'b0, o);
    n_tests++; if (o.resp_cycle != TO) begin n_fail++; $display("FAIL term_cycle: got %0d required %0d", o.resp_cycle, TO); end
    n_tests++; if ({o.rsp_valid, o.rsp_data, o.rsp_exc} !== {oh(g), 16'h1234, 3'b010}) begin n_fail++; $display("FAIL term_real_wins: got %b %h %b required %b 1234 010", o.rsp_valid, o.rsp_data, o.rsp_exc, oh(g)); end
    ptr_m = (g + 1) % N;
  endtask

  task automatic test_hold_ack();
    obs_t o;
    int g;
    logic [15:0] res;
    set_ops(0); set_ops(1); set_ops(2);
    Req_valid = 4'b0001;
    g = rr_pick(Req_valid, ptr_m);
    res = 16'($urandom);
    run_txn(2, res, 3'b001, 10, 1'b0, 4'b0110, '1, 1'b0, o);
    n_tests++; if (o.gid !== 2'(g)) begin n_fail++; $display("FAIL hold_grant: got %0d required %0d", o.gid, g); end
    n_tests++; if (!o.stable || o.rsp_data !== res) begin n_fail++; $display("FAIL hold_stable: got stable=%0d data %h required stable=1 data %h", o.stable, o.rsp_data, res); end
    n_tests++; if (o.rsp_after !== '0) begin n_fail++; $display("FAIL hold_release: got %b required 0000", o.rsp_after); end
    ptr_m = (g + 1) % N;
    g = rr_pick(Req_valid, ptr_m);
    run_txn(1, 16'($urandom), 3'b000, 0, 1'b0, '0, '0, 1'b0, o);
    n_tests++; if (o.issue_ticks != 1 || o.ack !== oh(g) || g != 1) begin n_fail++; $display("FAIL hold_next_grant: got ack %b after %0d ticks required %b after 1", o.ack, o.issue_ticks, oh(1)); end
    ptr_m = (g + 1) % N;
  endtask

  task automatic test_reset_mid_wait();
    int g;
    logic [15:0] res;
    set_ops(0); set_ops(2);
    Req_valid = 4'b0001;
    g = rr_pick(Req_valid, ptr_m);
    tick();
    n_tests++; if (Req_ack !== oh(g) || Add_data_valid !== 1'b1) begin n_fail++; $display("FAIL rmw_issue: got %b %b required %b 1", Req_ack, Add_data_valid, oh(g)); end
    Req_valid = 4'b0100;
    tick(); tick(); tick();
    n_tests++; if (Busy !== 1'b1 || Rsp_valid !== '0) begin n_fail++; $display("FAIL rmw_waiting: got busy %b rsp %b required busy 1 rsp 0000", Busy, Rsp_valid); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    ptr_m = 0; drop_m = 0;
    n_tests++;
    if ({Req_ack, Rsp_valid, Rsp_dataout, Rsp_exc, Add_datain1, Add_datain2, Add_mode,
         Add_data_valid, Busy, Grant_id, Drop_cnt} !== '0) begin
      n_fail++; $display("FAIL rmw_reset_outputs: got nonzero outputs, required all zero");
    end
    g = rr_pick(Req_valid, ptr_m);
    tick();
    n_tests++; if (Req_ack !== oh(g) || Grant_id !== 2'(g) || Add_datain1 !== Req_datain1[16*g +: 16]) begin n_fail++; $display("FAIL rmw_regrant: got %b id %0d d1 %h required %b id %0d d1 %h", Req_ack, Grant_id, Add_datain1, oh(g), g, Req_datain1[16*g +: 16]); end
    Req_valid = '0;
    res = 16'($urandom);
    Add_dataout_valid = 1'b1; Add_dataout = res; Add_exc = 3'b011;
    tick();
    Add_dataout_valid = 1'b0;
    n_tests++; if (Rsp_valid !== oh(g) || Rsp_dataout !== res || Rsp_exc !== 3'b011) begin n_fail++; $display("FAIL rmw_rsp: got %b %h %b required %b %h 011", Rsp_valid, Rsp_dataout, Rsp_exc, oh(g), res); end
    Rsp_ack = oh(g);
    tick();
    Rsp_ack = '0;
    n_tests++; if (Rsp_valid !== '0 || Busy !== 1'b0) begin n_fail++; $display("FAIL rmw_release: got %b busy %b required 0000 busy 0", Rsp_valid, Busy); end
    ptr_m = (g + 1) % N;
  endtask

  task automatic test_random();
    obs_t o;
    int g, lat, dly;
    bit stray;
    logic [N-1:0] newr;
    logic [15:0] res;
    logic [2:0] exc;
    for (int t = 0; t < 20; t++) begin
      newr = 4'($urandom) & ~Req_valid;
      if ((Req_valid | newr) == '0) newr = oh(int'($urandom_range(0, N - 1)));
      for (int i = 0; i < N; i++) if (newr[i]) set_ops(i);
      Req_valid = Req_valid | newr;
      g = rr_pick(Req_valid, ptr_m);
      lat = int'($urandom_range(0, 8));
      dly = int'($urandom_range(0, 3));
      stray = (dly > 0) && ($urandom_range(0, 1) == 1);
      res = 16'($urandom); exc = 3'($urandom);
      run_txn(lat, res, exc, dly, 1'b0, '0, (t == 19) ? '0 : '1, stray, o);
      if (stray) drop_m++;
      n_tests++; if (o.ack !== oh(g) || o.gid !== 2'(g)) begin n_fail++; $display("FAIL rnd_grant%0d: got %b required %b", t, o.ack, oh(g)); end
      n_tests++; if (o.d1 !== Req_datain1[16*g +: 16] || o.d2 !== Req_datain2[16*g +: 16]) begin n_fail++; $display("FAIL rnd_operands%0d: got %h %h required %h %h", t, o.d1, o.d2, Req_datain1[16*g +: 16], Req_datain2[16*g +: 16]); end
      n_tests++; if (o.resp_cycle != lat + 1 || o.rsp_data !== res || o.rsp_exc !== exc || o.rsp_valid !== oh(g)) begin n_fail++; $display("FAIL rnd_rsp%0d: got cyc %0d %h %b required cyc %0d %h %b", t, o.resp_cycle, o.rsp_data, o.rsp_exc, lat + 1, res, exc); end
      n_tests++; if (!o.stable || o.rsp_after !== '0) begin n_fail++; $display("FAIL rnd_hold%0d: got stable=%0d after %b required stable=1 after 0000", t, o.stable, o.rsp_after); end
      ptr_m = (g + 1) % N;
    end
    n_tests++; if (Drop_cnt !== 8'(drop_m)) begin n_fail++; $display("FAIL rnd_drop_cnt: got %0d required %0d", Drop_cnt, drop_m); end
  endtask

  task automatic test_drop_saturate();
    Req_valid = '0;
    Add_dataout_valid = 1'b1;
    Add_dataout = 16'h5555;
    for (int i = 0; i < 260; i++) tick();
    Add_dataout_valid = 1'b0;
    drop_m = (drop_m + 260 > 255) ? 255 : drop_m + 260;
    n_tests++; if (Drop_cnt !== 8'(drop_m)) begin n_fail++; $display("FAIL drop_saturate: got %0d required %0d", Drop_cnt, drop_m); end
    n_tests++; if (Rsp_valid !== '0 || Busy !== 1'b0) begin n_fail++; $display("FAIL drop_no_rsp: got %b busy %b required 0000 busy 0", Rsp_valid, Busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_terminal();
    test_hold_ack();
    test_reset_mid_wait();
    test_random();
    test_drop_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
